// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver.
// Features: two-flop input synchroniser, 3-sample majority vote per bit and
// false-start rejection. It flags parity and framing errors and delivers each
// word on a valid/ready output. If an unread word is replaced, overrun pulses.

module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int CLK_DIV    = 1,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);

    localparam logic [CD_W-1:0] PRE_LAST  = CD_W'(CLK_DIV - 1);
    localparam logic [OS_W-1:0] OS_S0     = OS_W'(OVERSAMPLE / 2 - 2);
    localparam logic [OS_W-1:0] OS_S1     = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_DEC    = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);
    localparam logic            PAR_EN    = (PARITY != 0);
    localparam logic            PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state, state_next;

    logic                 rx_meta, rx_s, rx_prev;
    logic [CD_W-1:0]      pre_cnt;
    logic [OS_W-1:0]      os_cnt;
    logic [BC_W-1:0]      bit_cnt;
    logic                 s0, s1;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 stop_bad;
    logic                 complete;
    logic                 tick, at_s0, at_s1, at_dec, at_end;
    logic                 maj;
    logic                 par_calc;

    // The in-bit tick position (os_cnt + 1) selects the sample, decide and end-of-bit points.
    assign tick     = (state != S_IDLE) && (pre_cnt == PRE_LAST);
    assign at_s0    = tick && (os_cnt == OS_S0);
    assign at_s1    = tick && (os_cnt == OS_S1);
    assign at_dec   = tick && (os_cnt == OS_DEC);
    assign at_end   = tick && (os_cnt == OS_LAST);
    assign maj      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign par_calc = PAR_EN ? ((^shreg) ^ par_bit ^ PAR_ODD) : 1'b0;
    assign busy     = (state != S_IDLE);

    // Synchronise the asynchronous line and keep its previous value for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; complete marks the final stop-bit decision.
    always_comb begin
        state_next = state;
        complete   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s && rx_prev) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (at_dec && maj) begin
                    state_next = S_IDLE;
                end else if (at_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (at_end && (bit_cnt == DATA_LAST)) begin
                    state_next = PAR_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (at_end) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (at_dec && (bit_cnt == STOP_LAST)) begin
                    state_next = S_IDLE;
                    complete   = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Prescaler and tick counter; both stay at zero while idle so the start edge is E0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            os_cnt  <= '0;
        end else if (state == S_IDLE) begin
            pre_cnt <= '0;
            os_cnt  <= '0;
        end else begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + CD_W'(1);
            if (tick) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
            end
        end
    end

    // Capture the three votes, shift data, and collect parity and stop-bit results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0       <= 1'b1;
            s1       <= 1'b1;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_bad <= 1'b0;
        end else if (state == S_IDLE) begin
            bit_cnt  <= '0;
            stop_bad <= 1'b0;
        end else begin
            if (at_s0) begin
                s0 <= rx_s;
            end
            if (at_s1) begin
                s1 <= rx_s;
            end
            if (at_end) begin
                bit_cnt <= (state_next != state) ? '0 : bit_cnt + BC_W'(1);
            end
            if (at_dec && (state == S_DATA)) begin
                shreg <= {maj, shreg[DATA_BITS-1:1]};
            end
            if (at_dec && (state == S_PARITY)) begin
                par_bit <= maj;
            end
            if (at_dec && (state == S_STOP) && !maj) begin
                stop_bad <= 1'b1;
            end
        end
    end

    // Output register with valid/ready handshake; a completion into an unread word pulses overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                data_out   <= shreg;
                parity_err <= par_calc;
                frame_err  <= stop_bad | ~maj;
                data_valid <= 1'b1;
                overrun    <= data_valid && !data_ready;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg. Three instances cover the
// default 8N1 set-up, even parity, and 7 data bits / 2 stop bits / CLK_DIV=4.

module tb_uart_rx_cfg;

    logic clk = 1'b0;
    logic reset;

    logic       rx_a, rx_p, rx_c;
    logic       ready_a, ready_p, ready_c;
    logic [7:0] data_a, data_p;
    logic [6:0] data_c;
    logic       dv_a, perr_a, ferr_a, ovr_a, busy_a;
    logic       dv_p, perr_p, ferr_p, ovr_p, busy_p;
    logic       dv_c, perr_c, ferr_c, ovr_c, busy_c;

    int n_checks = 0;
    int n_fail   = 0;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    uart_rx_cfg dut_a (
        .clk(clk), .reset(reset), .rx(rx_a),
        .data_out(data_a), .data_valid(dv_a), .data_ready(ready_a),
        .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_cfg #(.PARITY(2)) dut_p (
        .clk(clk), .reset(reset), .rx(rx_p),
        .data_out(data_p), .data_valid(dv_p), .data_ready(ready_p),
        .parity_err(perr_p), .frame_err(ferr_p), .overrun(ovr_p), .busy(busy_p)
    );

    uart_rx_cfg #(.DATA_BITS(7), .STOP_BITS(2), .CLK_DIV(4)) dut_c (
        .clk(clk), .reset(reset), .rx(rx_c),
        .data_out(data_c), .data_valid(dv_c), .data_ready(ready_c),
        .parity_err(perr_c), .frame_err(ferr_c), .overrun(ovr_c), .busy(busy_c)
    );

    task automatic drive_line(input int which, input logic v);
        case (which)
            0:       rx_a = v;
            1:       rx_p = v;
            default: rx_c = v;
        endcase
    endtask

    // Bit 0 of bits is the start bit; each bit is held for bit_clks clocks.
    task automatic send_frame(input int which, input logic [15:0] bits,
                              input int nbits, input int bit_clks);
        for (int i = 0; i < nbits; i++) begin
            drive_line(which, bits[i]);
            repeat (bit_clks) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_a = 1'b1; rx_p = 1'b1; rx_c = 1'b1;
        ready_a = 1'b0; ready_p = 1'b0; ready_c = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({data_a, dv_a, perr_a, ferr_a, ovr_a, busy_a} !== 13'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_a: got %0h expected 0", {data_a, dv_a, perr_a, ferr_a, ovr_a, busy_a});
        end
        n_checks++;
        if ({data_p, dv_p, perr_p, ferr_p, ovr_p, busy_p} !== 13'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_p: got %0h expected 0", {data_p, dv_p, perr_p, ferr_p, ovr_p, busy_p});
        end
        n_checks++;
        if ({data_c, dv_c, perr_c, ferr_c, ovr_c, busy_c} !== 12'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_c: got %0h expected 0", {data_c, dv_c, perr_c, ferr_c, ovr_c, busy_c});
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // 8N1 0xA5: rx falls at N0, sync takes 2 edges, completion 153 ticks later -> seen at negedge 156.
    task automatic test_timing_8n1();
        int rise = 0;
        int dv_cycles = 0;
        logic [7:0] cap_data = 8'h0;
        logic cap_perr = 1'b1, cap_ferr = 1'b1;
        ready_a = 1'b1;
        @(negedge clk);
        fork
            send_frame(0, 16'({1'b1, 8'hA5, 1'b0}), 10, 16);
            begin
                for (int i = 1; i <= 200; i++) begin
                    @(negedge clk);
                    if (dv_a) begin
                        dv_cycles++;
                        if (rise == 0) begin
                            rise = i; cap_data = data_a; cap_perr = perr_a; cap_ferr = ferr_a;
                        end
                    end
                end
            end
        join
        n_checks++;
        if (rise !== 156) begin n_fail++; $display("[TB] FAIL a5_latency: got %0d expected 156", rise); end
        n_checks++;
        if (cap_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL a5_data: got %0h expected a5", cap_data); end
        n_checks++;
        if ({cap_perr, cap_ferr} !== 2'b00) begin n_fail++; $display("[TB] FAIL a5_flags: got %0b expected 00", {cap_perr, cap_ferr}); end
        n_checks++;
        if (dv_cycles !== 1) begin n_fail++; $display("[TB] FAIL a5_valid_width: got %0d expected 1", dv_cycles); end
    endtask

    // Low for 6 clocks: votes at ticks 7..9 see high, so the receiver gives up without output.
    task automatic test_false_start();
        logic busy_seen = 1'b0, dv_seen = 1'b0;
        @(negedge clk);
        fork
            begin
                drive_line(0, 1'b0);
                repeat (6) @(negedge clk);
                drive_line(0, 1'b1);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (busy_a) busy_seen = 1'b1;
                    if (dv_a) dv_seen = 1'b1;
                end
            end
        join
        n_checks++;
        if (busy_seen !== 1'b1) begin n_fail++; $display("[TB] FAIL false_start_busy: got %0b expected 1", busy_seen); end
        n_checks++;
        if (dv_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL false_start_valid: got %0b expected 0", dv_seen); end
        n_checks++;
        if (busy_a !== 1'b0) begin n_fail++; $display("[TB] FAIL false_start_idle: got %0b expected 0", busy_a); end
    endtask

    // Even parity, 0x3C has four ones: parity bit 1 is wrong, parity bit 0 is right.
    task automatic test_parity();
        logic pbits [2] = '{1'b1, 1'b0};
        logic exp_perr [2] = '{1'b1, 1'b0};
        ready_p = 1'b1;
        for (int k = 0; k < 2; k++) begin
            int words = 0;
            logic [7:0] cap_data = 8'h0;
            logic cap_perr = 1'bx, cap_ferr = 1'bx;
            @(negedge clk);
            fork
                send_frame(1, 16'({1'b1, pbits[k], 8'h3C, 1'b0}), 11, 16);
                begin
                    for (int i = 0; i < 220; i++) begin
                        @(negedge clk);
                        if (dv_p) begin
                            words++; cap_data = data_p; cap_perr = perr_p; cap_ferr = ferr_p;
                        end
                    end
                end
            join
            n_checks++;
            if (words !== 1) begin n_fail++; $display("[TB] FAIL parity_words[%0d]: got %0d expected 1", k, words); end
            n_checks++;
            if (cap_data !== 8'h3C) begin n_fail++; $display("[TB] FAIL parity_data[%0d]: got %0h expected 3c", k, cap_data); end
            n_checks++;
            if (cap_perr !== exp_perr[k]) begin n_fail++; $display("[TB] FAIL parity_err[%0d]: got %0b expected %0b", k, cap_perr, exp_perr[k]); end
            n_checks++;
            if (cap_ferr !== 1'b0) begin n_fail++; $display("[TB] FAIL parity_ferr[%0d]: got %0b expected 0", k, cap_ferr); end
        end
    endtask

    // 0x00 with a low stop bit, line held low 40 more bit times: one errored word, then silence.
    task automatic test_break();
        int words = 0;
        logic [7:0] cap_data = 8'hFF;
        logic cap_ferr = 1'b0;
        int words2 = 0;
        logic [7:0] cap2 = 8'h0;
        logic cap2_ferr = 1'b1;
        ready_a = 1'b1;
        @(negedge clk);
        fork
            begin
                send_frame(0, 16'({1'b0, 8'h00, 1'b0}), 10, 16);
                repeat (640) @(negedge clk);
            end
            begin
                for (int i = 0; i < 800; i++) begin
                    @(negedge clk);
                    if (dv_a) begin words++; cap_data = data_a; cap_ferr = ferr_a; end
                end
            end
        join
        n_checks++;
        if (words !== 1) begin n_fail++; $display("[TB] FAIL break_words: got %0d expected 1", words); end
        n_checks++;
        if (cap_data !== 8'h00) begin n_fail++; $display("[TB] FAIL break_data: got %0h expected 0", cap_data); end
        n_checks++;
        if (cap_ferr !== 1'b1) begin n_fail++; $display("[TB] FAIL break_ferr: got %0b expected 1", cap_ferr); end
        n_checks++;
        if (busy_a !== 1'b0) begin n_fail++; $display("[TB] FAIL break_no_retrigger: got %0b expected 0", busy_a); end
        drive_line(0, 1'b1);
        repeat (20) @(negedge clk);
        fork
            send_frame(0, 16'({1'b1, 8'h5A, 1'b0}), 10, 16);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (dv_a) begin words2++; cap2 = data_a; cap2_ferr = ferr_a; end
                end
            end
        join
        n_checks++;
        if ({words2, cap2, cap2_ferr} !== {32'd1, 8'h5A, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL break_recover: got words=%0d data=%0h ferr=%0b expected 1/5a/0", words2, cap2, cap2_ferr);
        end
    endtask

    // 0x11 then 0x22 with nobody reading: second completion overwrites and pulses overrun once.
    task automatic test_back_to_back();
        logic got_first = 1'b0;
        logic [7:0] first_data = 8'h0;
        logic first_ovr = 1'b1;
        int ovr_cnt = 0;
        int dv_drop = 0;
        ready_a = 1'b0;
        @(negedge clk);
        fork
            begin
                send_frame(0, 16'({1'b1, 8'h11, 1'b0}), 10, 16);
                send_frame(0, 16'({1'b1, 8'h22, 1'b0}), 10, 16);
            end
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (!got_first) begin
                        if (dv_a) begin got_first = 1'b1; first_data = data_a; first_ovr = ovr_a; end
                    end else begin
                        if (ovr_a) ovr_cnt++;
                        if (!dv_a) dv_drop++;
                    end
                end
            end
        join
        n_checks++;
        if ({got_first, first_data} !== {1'b1, 8'h11}) begin
            n_fail++; $display("[TB] FAIL b2b_first: got seen=%0b data=%0h expected 1/11", got_first, first_data);
        end
        n_checks++;
        if (first_ovr !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_first_ovr: got %0b expected 0", first_ovr); end
        n_checks++;
        if (ovr_cnt !== 1) begin n_fail++; $display("[TB] FAIL b2b_overrun_width: got %0d expected 1", ovr_cnt); end
        n_checks++;
        if (dv_drop !== 0) begin n_fail++; $display("[TB] FAIL b2b_valid_hold: got %0d drops expected 0", dv_drop); end
        n_checks++;
        if ({dv_a, data_a} !== {1'b1, 8'h22}) begin
            n_fail++; $display("[TB] FAIL b2b_second: got valid=%0b data=%0h expected 1/22", dv_a, data_a);
        end
        ready_a = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dv_a !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_accept: got %0b expected 0", dv_a); end
    endtask

    // 7 data, 2 stop, CLK_DIV=4: completion 153 ticks * 4 after E0 -> seen at negedge 615.
    task automatic test_cfg_stop2();
        int rise = 0;
        logic [6:0] cap_data = 7'h0;
        logic cap_perr = 1'b1, cap_ferr = 1'b0;
        ready_c = 1'b0;
        @(negedge clk);
        fork
            send_frame(2, 16'({1'b0, 1'b1, 7'h55, 1'b0}), 10, 64);
            begin
                for (int i = 1; i <= 700; i++) begin
                    @(negedge clk);
                    if (dv_c && rise == 0) begin
                        rise = i; cap_data = data_c; cap_perr = perr_c; cap_ferr = ferr_c;
                    end
                end
            end
        join
        drive_line(2, 1'b1);
        n_checks++;
        if (rise !== 615) begin n_fail++; $display("[TB] FAIL stop2_latency: got %0d expected 615", rise); end
        n_checks++;
        if (cap_data !== 7'h55) begin n_fail++; $display("[TB] FAIL stop2_data: got %0h expected 55", cap_data); end
        n_checks++;
        if ({cap_perr, cap_ferr} !== 2'b01) begin n_fail++; $display("[TB] FAIL stop2_flags: got %0b expected 01", {cap_perr, cap_ferr}); end
        n_checks++;
        if (dv_c !== 1'b1) begin n_fail++; $display("[TB] FAIL stop2_valid_hold: got %0b expected 1", dv_c); end
    endtask

    // Reset in the middle of the data bits, then a clean frame must still be received.
    task automatic test_reset_mid_frame();
        int words = 0;
        logic [6:0] cap_data = 7'h0;
        logic cap_perr = 1'b1, cap_ferr = 1'b1;
        repeat (10) @(negedge clk);
        drive_line(2, 1'b0);
        repeat (64) @(negedge clk);
        drive_line(2, 1'b1);
        repeat (64) @(negedge clk);
        drive_line(2, 1'b0);
        repeat (64) @(negedge clk);
        n_checks++;
        if (busy_c !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_busy_before: got %0b expected 1", busy_c); end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({data_c, dv_c, perr_c, ferr_c, ovr_c, busy_c} !== 12'h0) begin
            n_fail++; $display("[TB] FAIL midreset_outputs: got %0h expected 0", {data_c, dv_c, perr_c, ferr_c, ovr_c, busy_c});
        end
        drive_line(2, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        ready_c = 1'b1;
        fork
            send_frame(2, 16'({1'b1, 1'b1, 7'h2A, 1'b0}), 10, 64);
            begin
                for (int i = 0; i < 700; i++) begin
                    @(negedge clk);
                    if (dv_c) begin words++; cap_data = data_c; cap_perr = perr_c; cap_ferr = ferr_c; end
                end
            end
        join
        n_checks++;
        if (words !== 1) begin n_fail++; $display("[TB] FAIL midreset_words: got %0d expected 1", words); end
        n_checks++;
        if (cap_data !== 7'h2A) begin n_fail++; $display("[TB] FAIL midreset_data: got %0h expected 2a", cap_data); end
        n_checks++;
        if ({cap_perr, cap_ferr} !== 2'b00) begin n_fail++; $display("[TB] FAIL midreset_flags: got %0b expected 00", {cap_perr, cap_ferr}); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_timing_8n1();
        test_false_start();
        test_parity();
        test_break();
        test_back_to_back();
        test_cfg_stop2();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case anything stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. Data width, parity mode, stop-bit count, oversampling ratio and clock prescale are all configurable. Adds input synchronisation, 3-sample majority voting, false-start rejection, parity/framing error flags, and a valid/ready output with overrun detection. Sits between the serial pin and the byte-stream consumer (FIFO or register file).

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
OVERSAMPLE, 16, sample ticks per bit, even, >= 8
CLK_DIV, 1, clocks per sample tick, >= 1
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
rx  in  1  serial input, idle high, asynchronous to clk
data_out  out  DATA_BITS  received word
data_valid  out  1  data_out, parity_err and frame_err are valid
data_ready  in  1  consumer accepts the word when data_valid && data_ready
parity_err  out  1  parity mismatch on the word in data_out
frame_err  out  1  a stop bit sampled 0 on the word in data_out
overrun  out  1  one-cycle pulse: an unaccepted word was overwritten
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async): data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, state IDLE. The two-flop rx synchroniser resets to 1 (rx_s). Reset mid-frame abandons the frame; no output update.
- Frame: B = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bits. Bit b=0 is the start bit.
- States: IDLE, START, DATA, PARITY (skipped when PARITY=0), STOP.
- IDLE: on an edge where rx_s==0 and its previous value was 1, go to START. This edge is E0. The prescaler and tick counter clear to 0. A line held low (break) never retriggers until it returns high.
- Ticks: tick k (k>=1) occurs at edge E0 + k*CLK_DIV. Bit b spans ticks b*OS+1 .. (b+1)*OS, where OS = OVERSAMPLE.
- Sampling: rx_s is sampled at ticks b*OS+OS/2-1, OS/2 and OS/2+1. The bit value is the majority of the 3 samples, decided at tick b*OS+OS/2+1.
- START: if the start-bit majority is 1, it is a false start: return to IDLE with no output and no error.
- DATA: shift data bits in LSB first.
- PARITY: computed error = XOR(data, parity bit) ^ (PARITY==1). A correct frame gives 0 for both odd and even modes.
- STOP: each stop-bit majority must be 1, otherwise frame_err. After the last stop decision, go to IDLE on the same edge. A new start is accepted from the next edge.
- Completion edge: E0 + ((B-1)*OS + OS/2 + 1)*CLK_DIV. On this edge data_out, parity_err and frame_err load together and data_valid<=1. Errored frames are still delivered, with their flags set.
- Handshake: data_valid holds until an edge with data_valid && data_ready, after which it clears. Outputs stay stable while data_valid=1 and not accepted.
- Completion while data_valid=1 and data_ready=0: new word overwrites the old one, data_valid stays 1, overrun=1 for exactly one cycle.
- Completion in the same cycle as an accept: new word loads, data_valid stays 1, no overrun.
- Counters are sized for OS*CLK_DIV and B. They must not wrap within a frame.

Test Plan:
- Defaults, send 8N1 0xA5, data_ready=1 -> data_valid rises on edge E0+153; data_out=0xA5, parity_err=0, frame_err=0, held for 1 cycle.
- PARITY=2, send 0x3C with parity bit 1 (wrong) -> data_out=0x3C, parity_err=1. Resend with parity bit 0 -> parity_err=0.
- Send 0x00 with stop bit 0 (break), rx held low 40 bit times -> one word 0x00, frame_err=1. No further frames until rx returns high and falls again.
- rx low for 6 clocks, then high -> busy pulses, returns to IDLE, data_valid never set.
- Two back-to-back frames 0x11 then 0x22, data_ready=0 -> overrun pulse 1 cycle at second completion; data_out=0x22; data_valid stays 1 until ready.
- DATA_BITS=7, STOP_BITS=2, CLK_DIV=4, second stop bit 0 -> frame_err=1. Separately, assert reset mid-DATA -> all outputs at reset values, next clean frame received correctly.
